// File: rtl/reservoir_accumulator_if.sv
// Handshake and result bus between the ESN multiplier and the reservoir accumulator.
// The master drives a product vector plus input term; the slave returns the neuron and state vector.
interface reservoir_accumulator_if #(
  parameter int data_width     = 3,
  parameter int weight_size    = 2,
  parameter int reservoir_size = 4
);
  localparam int prod_width = data_width + weight_size - 1;

  logic                                 iValid;
  logic                                 oReady;
  logic [prod_width*reservoir_size-1:0] iProducts;
  logic [data_width-1:0]                iInput;
  logic                                 oNeuronValid;
  logic [data_width-1:0]                oNeuron;
  logic                                 oStateValid;
  logic [data_width*reservoir_size-1:0] oState;

  modport master (
    output iValid, iProducts, iInput,
    input  oReady, oNeuronValid, oNeuron, oStateValid, oState
  );

  modport slave (
    input  iValid, iProducts, iInput,
    output oReady, oNeuronValid, oNeuron, oStateValid, oState
  );
endinterface

// File: rtl/reservoir_accumulator.sv
// Serial accumulator for one ESN neuron per transaction: sums a row of signed
// products onto the neuron's input term, clips to data_width (hard-tanh), and
// assembles reservoir_size neurons into the next state vector.
module reservoir_accumulator #(
  parameter int data_width     = 3,
  parameter int weight_size    = 2,
  parameter int reservoir_size = 4
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  reservoir_accumulator_if.slave  bus
);
  localparam int prod_width = data_width + weight_size - 1;
  localparam int acc_width  = prod_width + $clog2(reservoir_size) + 1;
  localparam int cntWidth   = (reservoir_size > 1) ? $clog2(reservoir_size) : 1;
  localparam int vecWidth   = data_width * reservoir_size;

  typedef enum logic [1:0] {IDLE, ACCUM, ACT} state_t;

  state_t                                state;
  logic signed [acc_width-1:0]           acc;
  logic [cntWidth-1:0]                   elemCnt;
  logic [cntWidth-1:0]                   neuronIdx;
  logic [prod_width*reservoir_size-1:0]  productsReg;
  logic [vecWidth-1:0]                   shadow;
  logic [vecWidth-1:0]                   shadowNext;
  logic signed [prod_width-1:0]          curProd;
  logic signed [data_width-1:0]          satVal;

  logic                                  readyReg;
  logic                                  neuronValidReg;
  logic [data_width-1:0]                 neuronReg;
  logic                                  stateValidReg;
  logic [vecWidth-1:0]                   stateReg;

  function automatic logic signed [acc_width-1:0] sextProd(input logic signed [prod_width-1:0] p);
    return {{(acc_width-prod_width){p[prod_width-1]}}, p};
  endfunction

  function automatic logic signed [acc_width-1:0] sextInput(input logic signed [data_width-1:0] x);
    return {{(acc_width-data_width){x[data_width-1]}}, x};
  endfunction

  // Integer hard-tanh: clip the wide sum into the signed data_width range.
  function automatic logic signed [data_width-1:0] saturate(input logic signed [acc_width-1:0] v);
    logic signed [acc_width-1:0] hi;
    logic signed [acc_width-1:0] lo;
    hi = {{(acc_width-data_width+1){1'b0}}, {(data_width-1){1'b1}}};
    lo = {{(acc_width-data_width+1){1'b1}}, {(data_width-1){1'b0}}};
    if (v > hi)      return hi[data_width-1:0];
    else if (v < lo) return lo[data_width-1:0];
    else             return v[data_width-1:0];
  endfunction

  assign curProd = $signed(productsReg[elemCnt*prod_width +: prod_width]);
  assign satVal  = saturate(acc);

  // Shadow vector with the current neuron's slot replaced by the clipped sum.
  always_comb begin
    shadowNext = shadow;
    shadowNext[neuronIdx*data_width +: data_width] = satVal;
  end

  // Control FSM: accept, accumulate serially, activate and publish.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state          <= IDLE;
      acc            <= '0;
      elemCnt        <= '0;
      neuronIdx      <= '0;
      productsReg    <= '0;
      shadow         <= '0;
      readyReg       <= 1'b1;
      neuronValidReg <= 1'b0;
      neuronReg      <= '0;
      stateValidReg  <= 1'b0;
      stateReg       <= '0;
    end else begin
      neuronValidReg <= 1'b0;
      stateValidReg  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iValid && readyReg) begin
            productsReg <= bus.iProducts;
            acc         <= sextInput($signed(bus.iInput));
            elemCnt     <= '0;
            readyReg    <= 1'b0;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          acc     <= acc + sextProd(curProd);
          elemCnt <= elemCnt + cntWidth'(1);
          if (elemCnt == cntWidth'(reservoir_size - 1)) state <= ACT;
        end
        ACT: begin
          shadow         <= shadowNext;
          neuronReg      <= satVal;
          neuronValidReg <= 1'b1;
          if (neuronIdx == cntWidth'(reservoir_size - 1)) begin
            stateReg      <= shadowNext;
            stateValidReg <= 1'b1;
            neuronIdx     <= '0;
          end else begin
            neuronIdx <= neuronIdx + cntWidth'(1);
          end
          readyReg <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          readyReg <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.oReady       = readyReg;
  assign bus.oNeuronValid = neuronValidReg;
  assign bus.oNeuron      = neuronReg;
  assign bus.oStateValid  = stateValidReg;
  assign bus.oState       = stateReg;
endmodule

// File: tb/tb_reservoir_accumulator.sv
// Scoreboard bench for reservoir_accumulator (data_width=3, weight_size=2, reservoir_size=4).
module tb_reservoir_accumulator;
  localparam int DW = 3;
  localparam int WS = 2;
  localparam int RS = 4;
  localparam int PW = DW + WS - 1;

  typedef struct packed {
    logic [DW-1:0]    neuron;
    logic             sv;
    logic [DW*RS-1:0] state;
    int               hs;
  } exp_t;

  logic iClk;
  logic iRst_n;
  int   cycleCnt;
  int   testsRun;
  int   testsFailed;

  exp_t             sb[$];
  logic [DW*RS-1:0] modelShadow;
  int               modelIdx;
  logic [DW-1:0]    pubNeuron;
  logic [DW*RS-1:0] pubState;
  int               lastHs;
  bit               prevHold;

  reservoir_accumulator_if #(.data_width(DW), .weight_size(WS), .reservoir_size(RS)) bus ();

  reservoir_accumulator #(.data_width(DW), .weight_size(WS), .reservoir_size(RS)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  always @(posedge iClk) cycleCnt <= cycleCnt + 1;

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cycleCnt);
    end
  endtask

  function automatic logic [DW-1:0] modelNeuron(input logic [PW*RS-1:0] p, input logic [DW-1:0] x);
    int s;
    logic signed [PW-1:0] e;
    s = int'($signed(x));
    for (int k = 0; k < RS; k++) begin
      e = p[k*PW +: PW];
      s += int'(e);
    end
    if (s > 3) s = 3;
    if (s < -4) s = -4;
    return DW'(s);
  endfunction

  task automatic modelReset();
    sb.delete();
    modelShadow = '0;
    modelIdx    = 0;
    pubNeuron   = '0;
    pubState    = '0;
    prevHold    = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_ready"},       32'(bus.oReady), 32'd1);
    checkVal({tag, "_neuronValid"}, 32'(bus.oNeuronValid), 32'd0);
    checkVal({tag, "_stateValid"},  32'(bus.oStateValid), 32'd0);
    checkVal({tag, "_neuron"},      32'(bus.oNeuron), 32'd0);
    checkVal({tag, "_state"},       32'(bus.oState), 32'd0);
  endtask

  // Called at a falling edge; hold keeps iValid asserted after acceptance.
  task automatic send(input logic [PW*RS-1:0] p, input logic [DW-1:0] x, input bit hold);
    int   waitCnt;
    exp_t e;
    bus.iValid    = 1'b1;
    bus.iProducts = p;
    bus.iInput    = x;
    waitCnt = 0;
    while (!bus.oReady && waitCnt < 20) begin
      @(negedge iClk);
      waitCnt++;
    end
    if (!bus.oReady) begin
      checkVal("acceptTimeout", 32'(bus.oReady), 32'd1);
      bus.iValid = 1'b0;
      return;
    end
    e.neuron = modelNeuron(p, x);
    modelShadow[modelIdx*DW +: DW] = e.neuron;
    e.sv    = (modelIdx == RS - 1);
    e.state = modelShadow;
    e.hs    = cycleCnt + 1;
    modelIdx = (modelIdx == RS - 1) ? 0 : modelIdx + 1;
    sb.push_back(e);
    if (hold && prevHold) checkVal("acceptSpacing", 32'(e.hs - lastHs), 32'(RS + 2));
    lastHs   = e.hs;
    prevHold = hold;
    @(posedge iClk);
    #1;
    bus.iProducts = (PW*RS)'($urandom);
    bus.iInput    = DW'($urandom);
    bus.iValid    = hold;
    @(negedge iClk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge iClk);
      n++;
    end
    checkVal("drainPending", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge iClk);
  endtask

  // Output monitor: pops the scoreboard on each neuron pulse and checks output stability.
  always @(negedge iClk) begin
    exp_t e;
    if (iRst_n) begin
      if (bus.oNeuronValid) begin
        if (sb.size() == 0) begin
          checkVal("unexpectedNeuron", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkVal("neuron", 32'(bus.oNeuron), 32'(e.neuron));
          checkVal("latency", 32'(cycleCnt - e.hs), 32'(RS + 1));
          checkVal("stateValid", 32'(bus.oStateValid), 32'(e.sv));
          if (e.sv) checkVal("state", 32'(bus.oState), 32'(e.state));
          pubNeuron = e.neuron;
          if (e.sv) pubState = e.state;
        end
      end else if (bus.oStateValid) begin
        checkVal("strayStateValid", 32'd1, 32'd0);
      end
      checkVal("neuronHold", 32'(bus.oNeuron), 32'(pubNeuron));
      checkVal("stateHold", 32'(bus.oState), 32'(pubState));
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    cycleCnt    = 0;
    lastHs      = 0;
    iRst_n      = 1'b0;
    bus.iValid    = 1'b0;
    bus.iProducts = '0;
    bus.iInput    = '0;
    modelReset();

    repeat (3) @(negedge iClk);
    checkResetOutputs("porReset");
    #2 iRst_n = 1'b1;
    @(negedge iClk);

    // Basic sum, positive and negative saturation, full state vector.
    send(16'h0F21, 3'd0, 1'b0);
    drain();
    checkVal("basicNeuron", 32'(bus.oNeuron), 32'd2);
    send(16'h7777, 3'd3, 1'b0);
    drain();
    checkVal("satPos", 32'(bus.oNeuron), 32'h3);
    send(16'h8888, 3'b100, 1'b0);
    drain();
    checkVal("satNeg", 32'(bus.oNeuron), 32'h4);
    send(16'h0000, 3'd0, 1'b0);
    drain();
    checkVal("fullVector", 32'(bus.oState), 32'h11A);

    // iValid held high: back-to-back accepts, garbage on the bus during ACCUM.
    for (int i = 0; i < 6; i++) send((PW*RS)'($urandom), DW'($urandom), 1'b1);
    bus.iValid = 1'b0;
    drain();

    // Reset in the middle of ACCUM with a nonzero neuron index.
    send(16'h1111, 3'd0, 1'b0);
    send(16'h2222, 3'd1, 1'b0);
    #2 iRst_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    modelReset();
    bus.iValid = 1'b0;
    @(negedge iClk);
    #2 iRst_n = 1'b1;
    @(negedge iClk);
    for (int i = 0; i < 4; i++) send((PW*RS)'($urandom), DW'($urandom), 1'b0);
    drain();

    // Random mix of isolated and held-valid transactions.
    for (int i = 0; i < 16; i++) send((PW*RS)'($urandom), DW'($urandom), 1'($urandom));
    bus.iValid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
